// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/accept byte handshake
module uart_tx #(
    parameter int p_div = 104
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_accept,
    output logic       o_tx,
    output logic       o_busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int CW = $clog2(p_div);
    localparam logic [CW-1:0] RELOAD = CW'(p_div - 1);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic          r_accept;
    logic          r_tx;
    logic          r_busy;
    assign o_accept = r_accept;
    assign o_tx     = r_tx;
    assign o_busy   = r_busy;
    // Frame sequencer; o_tx/o_busy are loaded from the next state so the line never glitches
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_sh     <= '0;
            r_accept <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_accept <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_sh     <= i_data;
                        r_cnt    <= RELOAD;
                        r_state  <= START;
                        r_accept <= 1'b1;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt   <= RELOAD;
                        r_bit   <= '0;
                        r_state <= DATA;
                        r_tx    <= r_sh[0];
                    end
                end
                DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt <= RELOAD;
                        r_sh  <= {1'b0, r_sh[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_sh[1];
                        end
                    end
                end
                STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame checks for uart_tx at p_div=4 and p_div=2
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v4 = 1'b0, v2 = 1'b0;
    logic [7:0] d4 = 8'h00, d2 = 8'h00;
    logic       acc4, tx4, busy4, acc2, tx2, busy2;

    uart_tx #(.p_div(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_data(d4),
        .o_accept(acc4), .o_tx(tx4), .o_busy(busy4)
    );
    uart_tx #(.p_div(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .i_data(d2),
        .o_accept(acc2), .o_tx(tx2), .o_busy(busy2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot = 0;
    int last_start = 0;

    typedef struct {
        bit         s2;
        logic [7:0] d;
        logic [9:0] seq;
        int         hold;
        bit         nxt;
        logic [7:0] nd;
        int         ew;
        bit         b2b;
        string      nm;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input bit s2, input bit v, input logic [7:0] d);
        if (s2) begin
            v2 = v;
            d2 = d;
        end else begin
            v4 = v;
            d4 = d;
        end
    endtask

    task automatic sample(input bit s2, output logic tx, output logic bz, output logic ac);
        tx = s2 ? tx2 : tx4;
        bz = s2 ? busy2 : busy4;
        ac = s2 ? acc2 : acc4;
    endtask

    // Offer a byte, then check every cycle of its frame against the expected line sequence
    task automatic send(input bit s2, input logic [7:0] d, input logic [9:0] seq, input int hold,
                        input bit nxt, input logic [7:0] nd, input int ew, input bit b2b,
                        input string nm);
        int   pd, w, bad, accs, k;
        logic tx, bz, ac;
        pd = s2 ? 2 : 4;
        drive(s2, 1'b1, d);
        w  = 0;
        ac = 1'b0;
        while (!ac && w < 50) begin
            @(posedge clk);
            #1;
            w++;
            sample(s2, tx, bz, ac);
        end
        if (!ac) begin
            chk({nm, " accept timeout"}, 0, 1);
            drive(s2, 1'b0, d);
            return;
        end
        if (ew > 0) chk({nm, " accept latency"}, w, ew);
        if (b2b) chk({nm, " start spacing"}, cyc - last_start, 41);
        last_start = cyc;
        accs = 0;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < pd; c++) begin
                k = b * pd + c;
                sample(s2, tx, bz, ac);
                if (tx !== seq[9-b]) bad++;
                if (bz !== 1'b1) bad++;
                if (ac === 1'b1) accs++;
                if (nxt && k >= 1) drive(s2, 1'b1, nd);
                else drive(s2, k < hold, d);
                @(posedge clk);
                #1;
            end
            chk($sformatf("%s bit%0d", nm, b), bad, 0);
        end
        sample(s2, tx, bz, ac);
        chk({nm, " idle tx"}, tx, 1);
        chk({nm, " idle busy"}, bz, 0);
        chk({nm, " idle accept"}, ac, 0);
        chk({nm, " accept pulses"}, accs, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic tx, bz, ac;
        tbl[0] = '{1'b0, 8'hA5, 10'b0101001011, 0, 1'b0, 8'h00, 1, 1'b0, "single_a5"};
        tbl[1] = '{1'b0, 8'hA5, 10'b0101001011, 3, 1'b0, 8'h00, 1, 1'b0, "held_valid"};
        tbl[2] = '{1'b0, 8'h00, 10'b0000000001, 0, 1'b1, 8'hFF, 1, 1'b0, "b2b_00"};
        tbl[3] = '{1'b0, 8'hFF, 10'b0111111111, 0, 1'b0, 8'h00, 1, 1'b1, "b2b_ff"};
        tbl[4] = '{1'b1, 8'h81, 10'b0100000011, 0, 1'b0, 8'h00, 1, 1'b0, "pdiv2_81"};

        rst = 1'b1;
        v4  = 1'b1;
        d4  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst tx", tx4, 1);
        chk("rst accept", acc4, 0);
        chk("rst busy", busy4, 0);
        chk("rst tx p2", tx2, 1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            send(tbl[i].s2, tbl[i].d, tbl[i].seq, tbl[i].hold, tbl[i].nxt, tbl[i].nd,
                 tbl[i].ew, tbl[i].b2b, tbl[i].nm);

        // Abort 0x5A in data bit 3, then a fresh byte must go out intact
        v4 = 1'b1;
        d4 = 8'h5A;
        ac = 1'b0;
        for (int w = 0; w < 50 && !ac; w++) begin
            @(posedge clk);
            #1;
            sample(1'b0, tx, bz, ac);
        end
        chk("midrst accept", ac, 1);
        v4 = 1'b0;
        repeat (17) begin
            @(posedge clk);
            #1;
        end
        chk("midrst pre tx", tx4, 1);
        chk("midrst pre busy", busy4, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst async tx", tx4, 1);
        chk("midrst async busy", busy4, 0);
        chk("midrst async accept", acc4, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(1'b0, 8'h3C, 10'b0001111001, 0, 1'b0, 8'h00, 1, 1'b0, "after_rst_3c");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the host link of the delay-line test chip. It takes bytes from the on-chip command/readback logic through a valid/accept handshake. Each accepted byte is sent as one 8N1 UART frame on a single output pin. It is the outbound end of the byte interface whose source holds valid until it sees a one-cycle accept pulse.

## Interface
- p_div, 104: clock cycles per UART bit; legal range 2..65535. The counter width is $clog2(p_div).
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  a byte is offered. The source holds it high, with i_data stable, until it sees o_accept.
- i_data  input  8  byte to send.
- o_accept  output  1  one-cycle pulse. The byte offered in the previous cycle has been taken.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  high while a frame is in progress (state != IDLE).

## Operation
- States:
  - IDLE: o_tx=1.
  - START: o_tx=0.
  - DATA: o_tx = shift register bit 0.
  - STOP: o_tx=1.
- Internal registers:
  - baud counter cnt, counting p_div-1 down to 0.
  - bit index bit_q, 0..7.
  - shift register sh_q, 8 bits.
- IDLE, with i_valid=1 at an edge:
  - latch i_data into sh_q
  - cnt <= p_div-1
  - state <= START
  - o_accept <= 1 for the next cycle only
- IDLE, with i_valid=0: hold.
- START, DATA and STOP all work the same way:
  - While cnt != 0, cnt decrements.
  - When cnt == 0, the bit period ends. cnt reloads to p_div-1 and the state advances.
- START to DATA: bit_q <= 0.
- End of each DATA bit period:
  - sh_q shifts right by one, filling with 0, so bits go out LSB first.
  - If bit_q == 7, go to STOP. Otherwise bit_q increments.
- End of STOP: go to IDLE, with no reload needed.
- o_accept is a registered output and is never high for two consecutive cycles.
- While not in IDLE, i_valid is ignored. Because o_accept is registered and the state has already left IDLE, a source still showing valid during the accept cycle cannot trigger a double accept.
- i_data changing while not in IDLE has no effect on the frame in flight.
- o_tx and o_busy are registered. They are decoded from next-state, so o_tx never glitches.

## Timing
- Reset values: o_tx=1, o_accept=0, o_busy=0, state IDLE, cnt=0, bit_q=0, sh_q=0.
- Reset behaviour:
  - Reset applies immediately and asynchronously.
  - Asserting reset mid-frame aborts the frame. o_tx returns to 1 without waiting for a clock.
  - After reset deasserts, the next accept happens at the first rising edge with i_valid=1.
- Accept timing:
  - Edge E samples i_valid=1 in IDLE.
  - In the cycle after E: o_accept=1, o_tx=0 and o_busy=1.
- Frame length:
  - The start bit, each of the 8 data bits and the stop bit each last exactly p_div cycles.
  - o_tx is low-going for the start bit starting at E+1. The line returns to IDLE at E+1+10*p_div.
- Back-to-back bytes:
  - At least one IDLE cycle separates frames, so the stop bit is effectively at least p_div+1 cycles.
  - Maximum throughput is one byte per 10*p_div+1 cycles.
- p_div=2 is the minimum. Each bit is then 2 cycles and the counter alternates 1,0.
- Cycle counts are exact with no drift. Frames are not re-synchronised to any external reference.

## Test plan
- Reset state: assert i_rst with i_valid=1. Required during reset and at the first edge after release:
  - o_tx=1, o_accept=0 and o_busy=0 while reset is held.
  - An accept on the first edge after release.
- Single byte (p_div=4): offer 0xA5.
  - o_accept is high for exactly 1 cycle.
  - o_tx follows 0,1,0,1,0,0,1,0,1,1, each value held for 4 cycles.
  - o_busy is high for 40 cycles.
- Held valid: the source keeps i_valid=1 for 3 cycles after o_accept because of its own latency. Required: only one frame is sent and exactly one o_accept pulse occurs.
- Back-to-back (p_div=4): offer 0x00, then 0xFF immediately after the first accept drops.
  - The second start bit begins exactly 41 cycles after the first.
  - The 0xFF data bits are all 1.
  - There are 2 accept pulses in total.
- Reset mid-frame: assert i_rst during data bit 3 of 0x5A. Required:
  - o_tx=1 asynchronously.
  - After release, a newly offered 0x3C is sent in full and correctly.
- Minimum divisor (p_div=2): send 0x81. o_tx follows 0,1,0,0,0,0,0,0,1,1, each value held for 2 cycles.
